imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate-generation stage between fetch and decode/execute of the RISC-V core.
- Decodes a 32-bit instruction into an XLEN-wide, correctly sign/zero-extended immediate, plus an immediate-format tag.
- Computes the PC-relative result (pc + imm) for branch, JAL and AUIPC.
- One registered stage with a valid/ready handshake and a 2-entry skid buffer, so full throughput survives downstream backpressure.

Parameters:
- XLEN, 32, datapath width: 32 or 64. Any other value is a fatal elaboration error.
- PC_W, XLEN, width of the pc fields. Must be ≤ XLEN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  instruction address.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  instruction passed through.
- out_pc  out  PC_W  pc passed through.
- out_imm  out  XLEN  decoded immediate.
- out_imm_type  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 CSR.
- out_target  out  XLEN  pc+imm for B/J/AUIPC, else 0.

Behaviour:
- Reset (async assert, sync deassert at clk edge): out_valid=0, in_ready=1, both buffer entries invalid, all data outputs 0.
- Transfer rules: input when in_valid & in_ready; output when out_valid & out_ready. in_valid must hold with stable data until accepted.
- Latency: an entry accepted at edge N is presented at out_* after edge N (1 cycle) when the buffer was empty.
- Buffer: main register plus skid register; in_ready = !skid_valid, registered. No combinational path from out_ready to in_ready.
- Buffer states and transitions:
  - EMPTY → ONE on accept.
  - ONE → ONE on simultaneous accept+output; → EMPTY on output only; → TWO on accept while stalled.
  - TWO: no accept. Output moves skid → main, returning to ONE.
- Ordering: strict FIFO order. No entry is duplicated or dropped under any in/out pattern.
- Decode is combinational on in_instr and captured in the buffer. Immediates, all sign-extended from bit 31 to XLEN unless stated:
  - I (opcodes 0010011 non-shift, 0000011, 1100111, 0011011 non-shift when XLEN=64): inst[31:20].
  - SHAMT (0010011 funct3 001/101; 0011011 when XLEN=64): inst[24:20] zero-extended when XLEN=32, inst[25:20] when XLEN=64; 0011011 always uses inst[24:20].
  - S (0100011): {inst[31:25], inst[11:7]}.
  - B (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U (0110111, 0010111): {inst[31:12], 12'b0}, sign-extended for XLEN=64.
  - J (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Any other opcode: type NONE, imm 0.
- out_target: pc zero-extended to XLEN plus imm, modulo 2^XLEN (wrap, no flag), for B, J and AUIPC only. 0 for JALR and all other opcodes.
- flush: at the next edge both entries are invalidated, out_valid=0 and in_ready=1. An input presented in the flush cycle is dropped. flush has priority over simultaneous accept/output.
- Reset mid-transfer: all entries lost, no partial outputs.

Optional Feature:
- IMM_CSR_EN defined: opcode 1110011 with funct3[2]=1 gives type CSR, imm = inst[19:15] zero-extended, target 0.
- IMM_CSR_EN undefined: all opcode 1110011 instructions give type NONE, imm 0.

Test Plan:
- XLEN=32, in 0xFFDFF06F (jal x0,-4), pc 0x100 → imm 0xFFFFFFFC, type 5, target 0x000000FC, one cycle after accept.
- 0xFFC12083 (lw) → imm 0xFFFFFFFC type 1. 0x00112423 (sw) → imm 0x8 type 2. 0x4030D093 (srai) → imm 0x3 type 6. 0x123450B7 (lui) → imm 0x12345000 type 4.
- XLEN=64, 0x800000B7 (lui) → imm 0xFFFFFFFF80000000. 0x03F0D093 (srli shamt 63) → imm 0x3F type 6.
- Stream 8 back-to-back instrs, out_ready low for 3 cycles mid-stream → in_ready drops after 2 held entries, all 8 emerge in order with none lost or duplicated.
- Buffer holding 2 entries, flush pulsed alongside in_valid → next cycle out_valid=0, in_ready=1, flushed input never appears.
- Reset asserted asynchronously between edges with 2 entries held → out_valid=0 immediately. With IMM_CSR_EN: 0x3402D073 (csrrwi) → imm 0x5 type 7.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate-generation stage with a 2-entry skid buffer.
// Optional CSR-immediate decode is enabled by defining IMM_CSR_EN.
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic [XLEN-1:0] out_target
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (PC_W > XLEN) begin : g_bad_pcw
        $fatal(1, "imm_gen_pipe: PC_W must not exceed XLEN");
    end

    localparam logic [2:0] T_NONE  = 3'd0;
    localparam logic [2:0] T_I     = 3'd1;
    localparam logic [2:0] T_S     = 3'd2;
    localparam logic [2:0] T_B     = 3'd3;
    localparam logic [2:0] T_U     = 3'd4;
    localparam logic [2:0] T_J     = 3'd5;
    localparam logic [2:0] T_SHAMT = 3'd6;
    localparam logic [2:0] T_CSR   = 3'd7;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic [XLEN-1:0] target;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state;
    state_t state_n;
    entry_t main_q;
    entry_t skid_q;
    entry_t dec;
    logic   accept;
    logic   emit;
    logic   load_main;
    logic   load_skid;
    logic   move_skid;

    logic [6:0]      op;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] sh5;
    logic [XLEN-1:0] sh_nat;
    logic            is_shift;

    assign op       = in_instr[6:0];
    assign f3       = in_instr[14:12];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
    assign imm_i    = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
    assign imm_s    = {{(XLEN-11){in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
    assign imm_b    = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                       in_instr[11:8], 1'b0};
    assign imm_u    = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
    assign imm_j    = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                       in_instr[30:21], 1'b0};
    assign sh5      = {{(XLEN-5){1'b0}}, in_instr[24:20]};
    assign sh_nat   = (XLEN == 64) ? {{(XLEN-6){1'b0}}, in_instr[25:20]} : sh5;

    // Decode the incoming instruction into the entry that will be buffered
    always_comb begin
        dec        = '0;
        dec.instr  = in_instr;
        dec.pc     = in_pc;
        case (op)
            7'b0010011: begin
                dec.typ = is_shift ? T_SHAMT : T_I;
                dec.imm = is_shift ? sh_nat : imm_i;
            end
            7'b0000011, 7'b1100111: begin
                dec.typ = T_I;
                dec.imm = imm_i;
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec.typ = is_shift ? T_SHAMT : T_I;
                    dec.imm = is_shift ? sh5 : imm_i;
                end
            end
            7'b0100011: begin
                dec.typ = T_S;
                dec.imm = imm_s;
            end
            7'b1100011: begin
                dec.typ = T_B;
                dec.imm = imm_b;
            end
            7'b0110111, 7'b0010111: begin
                dec.typ = T_U;
                dec.imm = imm_u;
            end
            7'b1101111: begin
                dec.typ = T_J;
                dec.imm = imm_j;
            end
`ifdef IMM_CSR_EN
            7'b1110011: begin
                if (f3[2]) begin
                    dec.typ = T_CSR;
                    dec.imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
                end
            end
`else
            7'b1110011: begin
                dec.typ = T_NONE;
            end
`endif
            default: begin
                dec.typ = T_NONE;
            end
        endcase
        if (op == 7'b1100011 || op == 7'b1101111 || op == 7'b0010111) begin
            dec.target = XLEN'(in_pc) + dec.imm;
        end
    end

    // Buffer occupancy register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_n;
    end

    // Occupancy transitions; flush overrides any transfer
    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (accept) state_n = ONE;
                ONE: begin
                    if (accept && !emit)      state_n = TWO;
                    else if (!accept && emit) state_n = EMPTY;
                end
                TWO:     if (emit) state_n = ONE;
                default: state_n = EMPTY;
            endcase
        end
    end

    // Handshake outputs depend only on registered occupancy
    always_comb begin
        out_valid = (state != EMPTY);
        in_ready  = (state != TWO);
    end

    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;
    assign load_main = !flush && ((state == EMPTY && accept) ||
                                  (state == ONE && accept && emit));
    assign load_skid = !flush && state == ONE && accept && !emit;
    assign move_skid = !flush && state == TWO && emit;

    // Main and skid payload registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)      main_q <= dec;
            else if (move_skid) main_q <= skid_q;
            if (load_skid)      skid_q <= dec;
        end
    end

    assign out_instr    = main_q.instr;
    assign out_pc       = main_q.pc;
    assign out_imm      = main_q.imm;
    assign out_imm_type = main_q.typ;
    assign out_target   = main_q.target;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances
// driven in lockstep and compared against a queue-based reference model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [31:0] pc32;
    logic [63:0] pc64;

    logic        r32, v32, r64, v64;
    logic [31:0] ins32, ins64;
    logic [31:0] p32, imm32, tg32;
    logic [63:0] p64, imm64, tg64;
    logic [2:0]  t32, t64;

    imm_gen_pipe #(.XLEN(32), .PC_W(32)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr), .in_pc(pc32),
        .out_valid(v32), .out_ready(out_ready), .out_instr(ins32), .out_pc(p32),
        .out_imm(imm32), .out_imm_type(t32), .out_target(tg32)
    );

    imm_gen_pipe #(.XLEN(64), .PC_W(64)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r64), .in_instr(in_instr), .in_pc(pc64),
        .out_valid(v64), .out_ready(out_ready), .out_instr(ins64), .out_pc(p64),
        .out_imm(imm64), .out_imm_type(t64), .out_target(tg64)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  typ;
        logic [63:0] target;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   checks = 0;
    int   errors = 0;
    int   popped = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode from the instruction-format rules, in signed arithmetic
    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc, input int xl);
        exp_t   e;
        longint v;
        logic [6:0] op;
        logic [2:0] f3;
        logic [63:0] mask;
        logic sh;
        op = ins[6:0];
        f3 = ins[14:12];
        sh = (f3 == 3'd1) || (f3 == 3'd5);
        mask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        v = 0;
        e.typ = 3'd0;
        case (op)
            7'h13: begin
                if (sh) begin
                    e.typ = 3'd6;
                    v = (xl == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
                end else begin
                    e.typ = 3'd1;
                    v = longint'($signed(ins[31:20]));
                end
            end
            7'h03, 7'h67: begin
                e.typ = 3'd1;
                v = longint'($signed(ins[31:20]));
            end
            7'h1B: begin
                if (xl == 64) begin
                    e.typ = sh ? 3'd6 : 3'd1;
                    v = sh ? longint'(ins[24:20]) : longint'($signed(ins[31:20]));
                end
            end
            7'h23: begin
                e.typ = 3'd2;
                v = longint'($signed({ins[31:25], ins[11:7]}));
            end
            7'h63: begin
                e.typ = 3'd3;
                v = (ins[31] ? -64'sd4096 : 64'sd0) + longint'(ins[7]) * 2048
                  + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            end
            7'h37, 7'h17: begin
                e.typ = 3'd4;
                v = longint'($signed(ins[31:12])) * 4096;
            end
            7'h6F: begin
                e.typ = 3'd5;
                v = (ins[31] ? -64'sd1048576 : 64'sd0) + longint'(ins[19:12]) * 4096
                  + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            end
`ifdef IMM_CSR_EN
            7'h73: begin
                if (ins[14]) begin
                    e.typ = 3'd7;
                    v = longint'(ins[19:15]);
                end
            end
`endif
            default: v = 0;
        endcase
        e.instr = ins;
        e.pc = pc & mask;
        e.imm = 64'(v) & mask;
        if (op == 7'h63 || op == 7'h6F || op == 7'h17)
            e.target = (e.pc + 64'(v)) & mask;
        else
            e.target = 64'd0;
        return e;
    endfunction

    // One clock: drive at posedge+1, check at negedge, update model after edge
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                       input logic ordy, input logic fl, output logic acc);
        logic em;
        in_valid = v;
        in_instr = ins;
        pc32 = pc[31:0];
        pc64 = pc;
        out_ready = ordy;
        flush = fl;
        @(negedge clk);
        chk("out_valid32", 64'(v32), 64'(q32.size() != 0));
        chk("in_ready32", 64'(r32), 64'(q32.size() < 2));
        chk("out_valid64", 64'(v64), 64'(q64.size() != 0));
        chk("in_ready64", 64'(r64), 64'(q64.size() < 2));
        if (q32.size() != 0) begin
            chk("instr32", 64'(ins32), 64'(q32[0].instr));
            chk("pc32", 64'(p32), q32[0].pc);
            chk("imm32", 64'(imm32), q32[0].imm);
            chk("type32", 64'(t32), 64'(q32[0].typ));
            chk("target32", 64'(tg32), q32[0].target);
        end
        if (q64.size() != 0) begin
            chk("instr64", 64'(ins64), 64'(q64[0].instr));
            chk("pc64", p64, q64[0].pc);
            chk("imm64", imm64, q64[0].imm);
            chk("type64", 64'(t64), 64'(q64[0].typ));
            chk("target64", tg64, q64[0].target);
        end
        acc = v & r32;
        em = v32 & ordy;
        @(posedge clk);
        #1;
        if (fl) begin
            q32.delete();
            q64.delete();
        end else begin
            if (em && q32.size() != 0) begin
                void'(q32.pop_front());
                void'(q64.pop_front());
                popped++;
            end
            if (acc) begin
                q32.push_back(model(ins, {32'd0, pc[31:0]}, 32));
                q64.push_back(model(ins, pc, 64));
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [12];
        logic [31:0] w;
        ops = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63,
                7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h7F};
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 11)];
        return w;
    endfunction

    logic        acc;
    logic        pv;
    logic        fl;
    logic [31:0] pins;
    logic [63:0] ppc;
    logic [31:0] bp_list [8];
    int          idx;
    int          base;
    logic        saw_low;

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_instr = '0;
        pc32 = '0;
        pc64 = '0;
        #2;
        chk("rst_out_valid", 64'(v32), 64'd0);
        chk("rst_in_ready", 64'(r32), 64'd1);
        chk("rst_imm", 64'(imm32), 64'd0);
        chk("rst_target", 64'(tg32), 64'd0);
        chk("rst_instr", 64'(ins32), 64'd0);
        chk("rst_imm64", imm64, 64'd0);
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed decode values
        cyc(1'b1, 32'hFFDFF06F, 64'h100, 1'b1, 1'b0, acc);
        chk("jal_imm", 64'(imm32), 64'hFFFF_FFFC);
        chk("jal_type", 64'(t32), 64'd5);
        chk("jal_target", 64'(tg32), 64'h0000_00FC);
        chk("jal_target64", tg64, 64'h0000_0000_0000_00FC);
        cyc(1'b1, 32'hFFC12083, 64'h200, 1'b1, 1'b0, acc);
        chk("lw_imm", 64'(imm32), 64'hFFFF_FFFC);
        chk("lw_type", 64'(t32), 64'd1);
        cyc(1'b1, 32'h00112423, 64'h204, 1'b1, 1'b0, acc);
        chk("sw_imm", 64'(imm32), 64'h8);
        chk("sw_type", 64'(t32), 64'd2);
        cyc(1'b1, 32'h4030D093, 64'h208, 1'b1, 1'b0, acc);
        chk("srai_imm", 64'(imm32), 64'h3);
        chk("srai_type", 64'(t32), 64'd6);
        cyc(1'b1, 32'h123450B7, 64'h20C, 1'b1, 1'b0, acc);
        chk("lui_imm", 64'(imm32), 64'h1234_5000);
        chk("lui_type", 64'(t32), 64'd4);
        chk("lui_target", 64'(tg32), 64'd0);
        cyc(1'b1, 32'h800000B7, 64'h210, 1'b1, 1'b0, acc);
        chk("lui64_imm", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("lui32_imm", 64'(imm32), 64'h8000_0000);
        cyc(1'b1, 32'h03F0D093, 64'h214, 1'b1, 1'b0, acc);
        chk("srli64_imm", imm64, 64'h3F);
        chk("srli32_imm", 64'(imm32), 64'h1F);
        chk("srli64_type", 64'(t64), 64'd6);
        cyc(1'b1, 32'h3402D073, 64'h218, 1'b1, 1'b0, acc);
`ifdef IMM_CSR_EN
        chk("csr_imm", 64'(imm32), 64'h5);
        chk("csr_type", 64'(t32), 64'd7);
`else
        chk("csr_imm", 64'(imm32), 64'h0);
        chk("csr_type", 64'(t32), 64'd0);
`endif
        chk("csr_target", 64'(tg32), 64'd0);
        cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

        // Backpressure: 8 instructions, out_ready low for 3 cycles
        bp_list = '{32'hFFDFF06F, 32'hFFC12083, 32'h00112423, 32'h4030D093,
                    32'h123450B7, 32'hFE000EE3, 32'h00001517, 32'h00008067};
        idx = 0;
        base = popped;
        saw_low = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (idx == 8 && q32.size() == 0) break;
            cyc(idx < 8, bp_list[idx % 8], 64'h1000 + 64'(idx * 4),
                !(c >= 2 && c <= 4), 1'b0, acc);
            if (acc) idx++;
            if (r32 === 1'b0) saw_low = 1'b1;
        end
        chk("bp_all_accepted", 64'(idx), 64'd8);
        chk("bp_all_emerged", 64'(popped - base), 64'd8);
        chk("bp_ready_dropped", 64'(saw_low), 64'd1);

        // Flush with two entries held and an input offered
        cyc(1'b1, 32'h00100093, 64'h300, 1'b0, 1'b0, acc);
        cyc(1'b1, 32'h00200113, 64'h304, 1'b0, 1'b0, acc);
        cyc(1'b1, 32'h00300193, 64'h308, 1'b1, 1'b1, acc);
        chk("flush2_out_valid", 64'(v32), 64'd0);
        chk("flush2_in_ready", 64'(r32), 64'd1);
        cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);
        // Flush while one entry held: offered input is accepted by handshake but dropped
        cyc(1'b1, 32'h00400213, 64'h30C, 1'b0, 1'b0, acc);
        cyc(1'b1, 32'h00500293, 64'h310, 1'b0, 1'b1, acc);
        chk("flush1_out_valid", 64'(v32), 64'd0);
        cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

        // Asynchronous reset with two entries held
        cyc(1'b1, 32'h00600313, 64'h400, 1'b0, 1'b0, acc);
        cyc(1'b1, 32'h00700393, 64'h404, 1'b0, 1'b0, acc);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("areset_out_valid", 64'(v32), 64'd0);
        chk("areset_in_ready", 64'(r32), 64'd1);
        chk("areset_imm", 64'(imm32), 64'd0);
        chk("areset_out_valid64", 64'(v64), 64'd0);
        q32.delete();
        q64.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Randomised traffic with held-until-accepted inputs and rare flushes
        pv = 1'b0;
        pins = '0;
        ppc = '0;
        for (int c = 0; c < 500; c++) begin
            if (!pv) begin
                pv = ($urandom_range(0, 3) != 0);
                pins = rand_instr();
                ppc = {$urandom, $urandom};
            end
            fl = ($urandom_range(0, 24) == 0);
            cyc(pv, pins, ppc, $urandom_range(0, 3) != 0, fl, acc);
            if (acc || fl) pv = 1'b0;
        end
        for (int c = 0; c < 4; c++) cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);
        chk("drain_empty", 64'(q32.size()), 64'd0);
        chk("drain_out_valid", 64'(v32), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
